// File: rtl/kgp_branch_pkg.sv
// Shared constants and decode helpers for the KGP_RISC branch unit.
package kgp_branch_pkg;

  localparam logic [1:0] OP_BRANCH = 2'b11;

  localparam logic [3:0] FC_B    = 4'b0000;
  localparam logic [3:0] FC_CALL = 4'b0001;
  localparam logic [3:0] FC_RET  = 4'b0010;
  localparam logic [3:0] FC_BR   = 4'b0011;
  localparam logic [3:0] FC_BZ   = 4'b0100;
  localparam logic [3:0] FC_BNZ  = 4'b0101;
  localparam logic [3:0] FC_BS   = 4'b0110;
  localparam logic [3:0] FC_BNS  = 4'b0111;
  localparam logic [3:0] FC_BCY  = 4'b1001;
  localparam logic [3:0] FC_BNCY = 4'b1010;
  localparam logic [3:0] FC_BV   = 4'b1011;
  localparam logic [3:0] FC_BNV  = 4'b1100;

  // Taken decision for every defined fcode; undefined codes are never taken.
  function automatic logic branch_taken(input logic [3:0] fc, input logic carry,
                                        input logic zero, input logic ovf, input logic sign);
    logic t;
    t = 1'b0;
    case (fc)
      FC_B, FC_CALL, FC_RET, FC_BR: t = 1'b1;
      FC_BZ:   t = zero;
      FC_BNZ:  t = ~zero;
      FC_BS:   t = sign;
      FC_BNS:  t = ~sign;
      FC_BCY:  t = carry;
      FC_BNCY: t = ~carry;
      FC_BV:   t = ovf;
      FC_BNV:  t = ~ovf;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic fcode_illegal(input logic [3:0] fc);
    return (fc == 4'b1000) || (fc >= 4'b1101);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: the oldest entry is overwritten when full.
module ras_stack #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         push_data,
  output logic [DATA_W-1:0]         top_data_c,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full_c,
  output logic                      empty_c,
  output logic                      overflow_c,
  output logic                      underflow_c
);
  import kgp_branch_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_tp;
  logic [CNT_W-1:0]  r_count;

  assign full_c      = (r_count == CNT_W'(DEPTH));
  assign empty_c     = (r_count == '0);
  assign top_data_c  = r_mem[r_tp];
  assign overflow_c  = push & full_c;
  assign underflow_c = pop & empty_c;
  assign count       = r_count;

  // Push has priority; a pop on an empty stack leaves everything untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_tp    <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[r_tp + PTR_W'(1)] <= push_data;
      r_tp                    <= r_tp + PTR_W'(1);
      if (!full_c) r_count <= r_count + CNT_W'(1);
    end else if (pop && !empty_c) begin
      r_tp    <= r_tp - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_unit_ras.sv
// Registered branch resolution with a hardware return-address stack.
// Statistics counters are built only when BRANCH_UNIT_STATS_EN is defined.
module branch_unit_ras #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned RA_W      = 32,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        br_valid,
  input  logic [1:0]                  opcode,
  input  logic [3:0]                  fcode,
  input  logic [PC_W-1:0]             label,
  input  logic [PC_W-1:0]             pc,
  input  logic                        carry_flag,
  input  logic                        zero_flag,
  input  logic                        ovf_flag,
  input  logic                        sign_flag,
  input  logic                        flush,
  output logic                        redirect_valid,
  output logic [PC_W-1:0]             redirect_pc,
  output logic                        ra_wr_en,
  output logic [RA_W-1:0]             ra_data,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow,
  output logic                        illegal_fcode,
  output logic [31:0]                 taken_cnt,
  output logic [31:0]                 not_taken_cnt
);
  import kgp_branch_pkg::*;

  logic            w_accept, w_call, w_ret, w_taken;
  logic            w_empty, w_full, w_ovf, w_unf;
  logic [PC_W-1:0] w_link, w_top, w_target;

  assign w_accept = br_valid && (opcode == OP_BRANCH) && !flush;
  assign w_call   = w_accept && (fcode == FC_CALL);
  assign w_ret    = w_accept && (fcode == FC_RET);
  assign w_taken  = branch_taken(fcode, carry_flag, zero_flag, ovf_flag, sign_flag);
  assign w_link   = pc + PC_W'(1);
  assign w_target = (fcode == FC_RET) ? (w_empty ? PC_W'(RESET_PC) : w_top) : label;

  ras_stack #(.DEPTH(RAS_DEPTH), .DATA_W(PC_W)) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push        (w_call),
    .pop         (w_ret),
    .push_data   (w_link),
    .top_data_c  (w_top),
    .count       (ras_count),
    .full_c      (w_full),
    .empty_c     (w_empty),
    .overflow_c  (w_ovf),
    .underflow_c (w_unf)
  );

  // Response register: every pulse defaults low so it lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      ra_wr_en       <= 1'b0;
      ra_data        <= '0;
      ras_overflow   <= 1'b0;
      ras_underflow  <= 1'b0;
      illegal_fcode  <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      ra_wr_en       <= 1'b0;
      ra_data        <= '0;
      ras_overflow   <= 1'b0;
      ras_underflow  <= 1'b0;
      illegal_fcode  <= 1'b0;
      if (w_accept) begin
        redirect_valid <= w_taken;
        redirect_pc    <= w_taken ? w_target : '0;
        ra_wr_en       <= w_call;
        ra_data        <= w_call ? RA_W'(w_link) : '0;
        ras_overflow   <= w_ovf;
        ras_underflow  <= w_unf;
        illegal_fcode  <= fcode_illegal(fcode);
      end
    end
  end

`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] r_taken_cnt, r_not_taken_cnt;

  // Saturating counters over accepted branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken_cnt     <= '0;
      r_not_taken_cnt <= '0;
    end else if (w_accept) begin
      if (w_taken && !(&r_taken_cnt)) r_taken_cnt <= r_taken_cnt + 32'd1;
      if (!w_taken && !(&r_not_taken_cnt)) r_not_taken_cnt <= r_not_taken_cnt + 32'd1;
    end
  end

  assign taken_cnt     = r_taken_cnt;
  assign not_taken_cnt = r_not_taken_cnt;
`else
  assign taken_cnt     = '0;
  assign not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_unit_ras.sv
// Bench for branch_unit_ras: directed table, multi-cycle RAS sequences, random vs. queue model.
module tb_branch_unit_ras;
  localparam int unsigned PC_W      = 10;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned RA_W      = 32;
  localparam int unsigned RESET_PC  = 0;
  localparam int unsigned CNT_W     = $clog2(RAS_DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, br_valid, carry_flag, zero_flag, ovf_flag, sign_flag, flush;
  logic [1:0] opcode;
  logic [3:0] fcode;
  logic [PC_W-1:0] label, pc;
  logic redirect_valid, ra_wr_en, ras_overflow, ras_underflow, illegal_fcode;
  logic [PC_W-1:0] redirect_pc;
  logic [RA_W-1:0] ra_data;
  logic [CNT_W-1:0] ras_count;
  logic [31:0] taken_cnt, not_taken_cnt;

  branch_unit_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH), .RA_W(RA_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .opcode(opcode), .fcode(fcode),
    .label(label), .pc(pc), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .ovf_flag(ovf_flag), .sign_flag(sign_flag), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ra_wr_en(ra_wr_en),
    .ra_data(ra_data), .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow), .illegal_fcode(illegal_fcode),
    .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic v; logic [1:0] op; logic [3:0] fc;
    logic [PC_W-1:0] label; logic [PC_W-1:0] pc;
    logic c; logic z; logic o; logic s; logic flush;
  } in_t;

  typedef struct {
    logic rv; logic [PC_W-1:0] rpc; logic raw; logic [RA_W-1:0] ra;
    logic [CNT_W-1:0] cnt; logic ovf; logic unf; logic ill;
  } exp_t;

  typedef struct { in_t in; exp_t ex; } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int ras_q[$];
  longint m_tk = 0;
  longint m_ntk = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic r, input logic v, input logic [1:0] op, input logic [3:0] fc,
                             input logic [PC_W-1:0] lb, input logic [PC_W-1:0] p,
                             input logic c, input logic z, input logic o, input logic s, input logic fl);
    in_t i;
    i.rst = r; i.v = v; i.op = op; i.fc = fc; i.label = lb; i.pc = p;
    i.c = c; i.z = z; i.o = o; i.s = s; i.flush = fl;
    return i;
  endfunction

  function automatic exp_t mkx(input logic rv, input logic [PC_W-1:0] rpc, input logic raw,
                               input logic [RA_W-1:0] ra, input logic [CNT_W-1:0] cnt,
                               input logic ovf, input logic unf, input logic ill);
    exp_t e;
    e.rv = rv; e.rpc = rpc; e.raw = raw; e.ra = ra; e.cnt = cnt;
    e.ovf = ovf; e.unf = unf; e.ill = ill;
    return e;
  endfunction

  // Reference: stack as a queue (back = top, front = oldest), decode from the fcode table.
  function automatic exp_t model_step(input in_t i);
    exp_t e;
    logic taken;
    int tgt;
    int link;
    e = mkx(0, 0, 0, 0, 0, 0, 0, 0);
    if (i.rst) begin
      ras_q.delete();
      m_tk = 0;
      m_ntk = 0;
      return e;
    end
    if (i.v && i.op == 2'b11 && !i.flush) begin
      taken = 1'b0;
      tgt = int'(i.label);
      link = (int'(i.pc) + 1) % (1 << PC_W);
      case (i.fc)
        4'd0, 4'd3: taken = 1'b1;
        4'd1: begin
          taken = 1'b1;
          e.raw = 1'b1;
          e.ra = RA_W'(link);
          if (ras_q.size() == int'(RAS_DEPTH)) begin
            void'(ras_q.pop_front());
            e.ovf = 1'b1;
          end
          ras_q.push_back(link);
        end
        4'd2: begin
          taken = 1'b1;
          if (ras_q.size() == 0) begin
            tgt = int'(RESET_PC);
            e.unf = 1'b1;
          end else begin
            tgt = ras_q.pop_back();
          end
        end
        4'd4:  taken = i.z;
        4'd5:  taken = !i.z;
        4'd6:  taken = i.s;
        4'd7:  taken = !i.s;
        4'd9:  taken = i.c;
        4'd10: taken = !i.c;
        4'd11: taken = i.o;
        4'd12: taken = !i.o;
        default: e.ill = 1'b1;
      endcase
      e.rv = taken;
      e.rpc = taken ? PC_W'(tgt) : '0;
      if (taken) m_tk++; else m_ntk++;
    end
    e.cnt = CNT_W'(ras_q.size());
    return e;
  endfunction

  task automatic apply(input in_t i, output exp_t e);
    e = model_step(i);
    rst = i.rst; br_valid = i.v; opcode = i.op; fcode = i.fc; label = i.label; pc = i.pc;
    carry_flag = i.c; zero_flag = i.z; ovf_flag = i.o; sign_flag = i.s; flush = i.flush;
    @(posedge clk);
    #1;
    check("redirect_valid", 64'(redirect_valid), 64'(e.rv));
    check("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
    check("ra_wr_en", 64'(ra_wr_en), 64'(e.raw));
    if (e.raw) check("ra_data", 64'(ra_data), 64'(e.ra));
    check("ras_count", 64'(ras_count), 64'(e.cnt));
    check("ras_overflow", 64'(ras_overflow), 64'(e.ovf));
    check("ras_underflow", 64'(ras_underflow), 64'(e.unf));
    check("illegal_fcode", 64'(illegal_fcode), 64'(e.ill));
`ifdef BRANCH_UNIT_STATS_EN
    check("taken_cnt", 64'(taken_cnt), 64'(m_tk));
    check("not_taken_cnt", 64'(not_taken_cnt), 64'(m_ntk));
`else
    check("taken_cnt", 64'(taken_cnt), 64'd0);
    check("not_taken_cnt", 64'(not_taken_cnt), 64'd0);
`endif
  endtask

  task automatic do_reset();
    exp_t e;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e);
  endtask

  vec_t tbl[13];

  initial begin
    exp_t e;
    in_t ri;

    tbl[0]  = '{mk(0, 1, 2'b11, 4'b0100, 10'h123, 10'h000, 0, 1, 0, 0, 0), mkx(1, 10'h123, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{mk(0, 1, 2'b11, 4'b0100, 10'h123, 10'h001, 0, 0, 0, 0, 0), mkx(0, 10'h000, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{mk(0, 1, 2'b11, 4'b0001, 10'h200, 10'h010, 0, 0, 0, 0, 0), mkx(1, 10'h200, 1, 32'h011, 1, 0, 0, 0)};
    tbl[3]  = '{mk(0, 1, 2'b11, 4'b0010, 10'h0aa, 10'h200, 0, 0, 0, 0, 0), mkx(1, 10'h011, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{mk(0, 1, 2'b11, 4'b0010, 10'h0aa, 10'h300, 0, 0, 0, 0, 0), mkx(1, 10'h000, 0, 0, 0, 0, 1, 0)};
    tbl[5]  = '{mk(0, 1, 2'b11, 4'b1110, 10'h0aa, 10'h004, 1, 1, 1, 1, 0), mkx(0, 10'h000, 0, 0, 0, 0, 0, 1)};
    tbl[6]  = '{mk(0, 1, 2'b11, 4'b0001, 10'h0aa, 10'h005, 0, 0, 0, 0, 1), mkx(0, 10'h000, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{mk(0, 0, 2'b11, 4'b0001, 10'h0aa, 10'h006, 0, 0, 0, 0, 0), mkx(0, 10'h000, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{mk(0, 1, 2'b01, 4'b0000, 10'h0aa, 10'h007, 0, 0, 0, 0, 0), mkx(0, 10'h000, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{mk(0, 1, 2'b11, 4'b1100, 10'h3ff, 10'h008, 0, 0, 0, 0, 0), mkx(1, 10'h3ff, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{mk(0, 1, 2'b11, 4'b1001, 10'h055, 10'h009, 0, 0, 0, 0, 0), mkx(0, 10'h000, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{mk(0, 1, 2'b11, 4'b0001, 10'h001, 10'h3ff, 0, 0, 0, 0, 0), mkx(1, 10'h001, 1, 32'h000, 1, 0, 0, 0)};
    tbl[12] = '{mk(0, 1, 2'b11, 4'b0010, 10'h0aa, 10'h001, 0, 0, 0, 0, 0), mkx(1, 10'h000, 0, 0, 0, 0, 0, 0)};

    rst = 1'b1; br_valid = 1'b0; opcode = '0; fcode = '0; label = '0; pc = '0;
    carry_flag = 1'b0; zero_flag = 1'b0; ovf_flag = 1'b0; sign_flag = 1'b0; flush = 1'b0;
    #1;
    do_reset();

    // Directed table against fixed expectations.
    for (int k = 0; k < 13; k++) begin
      apply(tbl[k].in, e);
      check($sformatf("tbl%0d.rv", k), 64'(redirect_valid), 64'(tbl[k].ex.rv));
      check($sformatf("tbl%0d.rpc", k), 64'(redirect_pc), 64'(tbl[k].ex.rpc));
      check($sformatf("tbl%0d.raw", k), 64'(ra_wr_en), 64'(tbl[k].ex.raw));
      if (tbl[k].ex.raw) check($sformatf("tbl%0d.ra", k), 64'(ra_data), 64'(tbl[k].ex.ra));
      check($sformatf("tbl%0d.cnt", k), 64'(ras_count), 64'(tbl[k].ex.cnt));
      check($sformatf("tbl%0d.unf", k), 64'(ras_underflow), 64'(tbl[k].ex.unf));
      check($sformatf("tbl%0d.ill", k), 64'(illegal_fcode), 64'(tbl[k].ex.ill));
    end

    // Nine calls overflow an 8-deep RAS, then drain it and underflow once.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      apply(mk(0, 1, 2'b11, 4'b0001, PC_W'(10'h100 + k), PC_W'(k), 0, 0, 0, 0, 0), e);
      check($sformatf("call%0d.ovf", k), 64'(ras_overflow), (k == 8) ? 64'd1 : 64'd0);
    end
    check("full.cnt", 64'(ras_count), 64'd8);
    for (int k = 0; k < 8; k++) begin
      apply(mk(0, 1, 2'b11, 4'b0010, 10'h0, 10'h0, 0, 0, 0, 0, 0), e);
      check($sformatf("ret%0d.rpc", k), 64'(redirect_pc), 64'(9 - k));
    end
    apply(mk(0, 1, 2'b11, 4'b0010, 10'h0, 10'h0, 0, 0, 0, 0, 0), e);
    check("ret_empty.rpc", 64'(redirect_pc), 64'(RESET_PC));
    check("ret_empty.unf", 64'(ras_underflow), 64'd1);
    check("ret_empty.cnt", 64'(ras_count), 64'd0);

    // Reset wins over a call presented in the same cycle, with 3 entries stacked.
    for (int k = 0; k < 3; k++)
      apply(mk(0, 1, 2'b11, 4'b0001, 10'h2, PC_W'(k + 5), 0, 0, 0, 0, 0), e);
    apply(mk(1, 1, 2'b11, 4'b0001, 10'h2, 10'h7, 0, 0, 0, 0, 0), e);
    check("rst.cnt", 64'(ras_count), 64'd0);
    check("rst.rv", 64'(redirect_valid), 64'd0);
    check("rst.raw", 64'(ra_wr_en), 64'd0);

    // Five taken and two not-taken branches for the statistics counters.
    do_reset();
    for (int k = 0; k < 5; k++)
      apply(mk(0, 1, 2'b11, 4'b0000, PC_W'(k), 10'h0, 0, 0, 0, 0, 0), e);
    apply(mk(0, 1, 2'b11, 4'b1000, 10'h1, 10'h0, 0, 0, 0, 0, 0), e);
    apply(mk(0, 1, 2'b11, 4'b0100, 10'h1, 10'h0, 0, 0, 0, 0, 0), e);
`ifdef BRANCH_UNIT_STATS_EN
    check("stats.taken", 64'(taken_cnt), 64'd5);
    check("stats.not_taken", 64'(not_taken_cnt), 64'd2);
`else
    check("stats.taken", 64'(taken_cnt), 64'd0);
    check("stats.not_taken", 64'(not_taken_cnt), 64'd0);
`endif

    // Random traffic biased toward branches and call/ret.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      ri = mk(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
              ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 2)),
              ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 2)) : 4'($urandom),
              PC_W'($urandom), PC_W'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
      apply(ri, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_unit_ras.md
Name: branch_unit_ras

Overview:
- Registered branch-resolution unit for the KGP_RISC core. It is the parametrised successor of the combinational branch decoder.
- Resolves unconditional, conditional, call and return branches from opcode/fcode/flags. Produces a one-cycle redirect pulse to the PC stage.
- Keeps a hardware return-address stack (RAS) of configurable depth, so nested calls and returns work without a single ra register.
- Sits between the decode/execute stage (flags, label) and the PC mux.

Parameters:
- PC_W, 10, width of PC, label and redirect target.
- RAS_DEPTH, 8, RAS entries (power of 2, at least 2).
- RA_W, 32, width of the ra write-back data, zero-extended from PC_W.
- RESET_PC, 0, target used on a return with an empty RAS.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- br_valid  in  1  instruction present this cycle.
- opcode  in  2  instruction class; 2'b11 = branch.
- fcode  in  4  branch function code.
- label  in  PC_W  branch target.
- pc  in  PC_W  address of the branch instruction.
- carry_flag, zero_flag, ovf_flag, sign_flag  in  1 each  ALU flags.
- flush  in  1  kill the current instruction.
- redirect_valid  out  1  one-cycle pulse: load redirect_pc.
- redirect_pc  out  PC_W  next-PC target.
- ra_wr_en  out  1  write ra_data to the link register.
- ra_data  out  RA_W  return address, zero-extended.
- ras_count  out  clog2(RAS_DEPTH)+1  current stack occupancy.
- ras_overflow  out  1  one-cycle pulse when a call drops the oldest entry.
- ras_underflow  out  1  one-cycle pulse on a return with an empty RAS.
- illegal_fcode  out  1  one-cycle pulse on an undefined fcode.
- taken_cnt, not_taken_cnt  out  32 each  statistics counters (see Optional Feature).

Behaviour:
- Reset: every output is 0, the RAS is cleared and the pointers are reset. Reset has priority over all other inputs, including mid-sequence.
- An instruction is accepted when br_valid=1, opcode=2'b11 and flush=0. Otherwise no state changes and all pulses are 0 on the next cycle.
- Latency: all outputs are registered. Response appears exactly 1 cycle after acceptance; pulses last 1 cycle.
- A new branch may be accepted every cycle. A ret in the cycle after a call sees the pushed entry.
- fcode decode (taken → redirect_valid=1):
  - 0000 b: always taken, target label.
  - 0001 call: taken to label; push (pc+1) mod 2^PC_W; ra_wr_en=1, ra_data=pc+1.
  - 0010 ret: pop the RAS top and redirect to it. If empty, redirect to RESET_PC and pulse ras_underflow; count stays 0.
  - 0011 br: taken, target label.
  - 0100 bz: taken if zero_flag=1. 0101 bnz: taken if zero_flag=0.
  - 0110 bs: taken if sign_flag=1. 0111 bns: taken if sign_flag=0.
  - 1001 bcy: taken if carry_flag=1. 1010 bncy: taken if carry_flag=0.
  - 1011 bv: taken if ovf_flag=1. 1100 bnv: taken if ovf_flag=0.
  - 1000, 1101, 1110, 1111: not taken; pulse illegal_fcode.
- Not taken: redirect_valid=0 and redirect_pc=0.
- RAS structure: circular buffer with top pointer tp.
  - Push writes mem[tp+1] and increments tp modulo RAS_DEPTH.
  - count saturates at RAS_DEPTH. A push while full overwrites the oldest entry and pulses ras_overflow.
  - Pop reads mem[tp] and decrements tp and count.
- Flush: a flush in the same cycle as br_valid discards the instruction with no RAS change and no pulses. A flush never cancels a redirect already registered.

Optional Feature:
- Macro BRANCH_UNIT_STATS_EN.
- When defined: taken_cnt and not_taken_cnt count accepted conditional and unconditional branches (illegal fcodes count as not taken). Both saturate at 2^32-1 and clear on rst.
- When undefined: both ports are tied to 0 and no counter logic is synthesised.

Decomposition:
- Package kgp_branch_pkg: opcode constant OP_BRANCH=2'b11, fcode localparams (FC_B … FC_BNV), and a taken-evaluation function taking fcode and the four flags.
- One sub-module, ras_stack: parametrised circular stack with push/pop, full/empty, count and an overflow/underflow indication.

Test Plan:
- Reset, then bz with zero_flag=1, label=0x123 → next cycle: redirect_valid=1, redirect_pc=0x123. Same with zero_flag=0 → redirect_valid=0, redirect_pc=0.
- call at pc=0x010 → label 0x200, then ret next cycle → cycle 1: ra_data=0x011, ra_wr_en=1; cycle 2: redirect_pc=0x011, ras_count back to 0.
- RAS_DEPTH=8: 9 consecutive calls from pc=0..8 → 9th pulses ras_overflow, count=8; 8 rets return 9,8,…,2; a 9th ret redirects to RESET_PC with ras_underflow=1.
- ret on empty stack straight after reset → redirect_pc=0, ras_underflow=1, count stays 0.
- fcode=4'b1110 → illegal_fcode=1, redirect_valid=0. A call with flush=1 → no push, no ra_wr_en.
- Assert rst with 3 entries on the RAS → next cycle count=0 and all outputs 0. With BRANCH_UNIT_STATS_EN: 5 taken + 2 not-taken branches give taken_cnt=5, not_taken_cnt=2.
